multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencer that turns the single-cycle MIPS datapath into a multi-cycle machine sharing one memory port and one ALU.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Memory accesses use a req/ready handshake with a watchdog timeout.
- Sits between the instruction register opcode field and all datapath enables.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready cycles tolerated in any memory wait state before FAULT (legal range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 allows new instruction fetches.
- op_code  in  6  IR[31:26]; stable outside FETCH.
- zero_flag  in  1  ALU zero; consumed by datapath via pc_write_cond.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero_flag.
- pc_source  out  2  00 = ALU result, 01 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = rs data.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired  out  CNT_W  retired-instruction count; wraps to 0.
- fault  out  1  sticky; illegal opcode or memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (reset=0, async): state=IDLE, retired=0, timer=0, fault=0. All outputs are decoded from state, so every strobe is 0 and every select is 0.
- Outputs are a pure function of state, mem_ready and op_code; unlisted outputs are 0.
- IDLE(0): run=1 -> FETCH.
- FETCH(1): mem_req, mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; that edge -> DECODE.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - op_code 000000 or 000001 -> EXEC.
  - 100010 or 101011 -> MEM_ADDR.
  - 000100 -> BRANCH.
  - any other -> FAULT.
- MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. op_code 100010 -> MEM_RD, else -> MEM_WR.
- MEM_RD(4): mem_req, mem_read, i_or_d=1. mem_ready -> MEM_WB.
- MEM_WB(5): reg_write, mem_to_reg=1, reg_dst=0. Retires.
- MEM_WR(6): mem_req, mem_write, i_or_d=1. mem_ready -> retire.
- EXEC(7): alu_src_a=1, alu_src_b=00. alu_op=10 for 000000, 01 for 000001. -> ALU_WB.
- ALU_WB(8): reg_write, reg_dst=1, mem_to_reg=0. Retires.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Retires.
- Retire:
  - instr_done=1 that cycle; retired increments at the edge.
  - Next state is FETCH if run=1, else IDLE. run is sampled only at retire and in IDLE; deasserting run never aborts an instruction.
- Memory watchdog, in FETCH, MEM_RD and MEM_WR:
  - timer clears on entry to each of these states.
  - Each cycle with mem_ready=0: if timer==MEM_TIMEOUT-1 -> FAULT, else timer increments.
  - mem_ready=1 in the timeout cycle wins: normal transition.
- FAULT(10): fault=1 and all strobes 0. Exits only via reset. retired holds its value.
- Unused encodings 11..15 -> FAULT.
- Latency in cycles, with mem_ready tied high:
  - R-type = 4 (FETCH, DECODE, EXEC, ALU_WB).
  - BEQ = 3.
  - SW = 4.
  - LW = 5.
  - Each not-ready cycle adds 1.
- Reset asserted mid-instruction: immediate return to IDLE; no partial strobe after the reset edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - State encoding constants 0..10.
  - Opcode constants: OP_ADD=000000, OP_SUB=000001, OP_LW=100010, OP_SW=101011, OP_BEQ=000100.
  - Encodings for alu_src_b, alu_op and pc_source.
- One sub-module, mem_wait_timer: clear/enable/expired counter, width $clog2(MEM_TIMEOUT+1).

Test Plan:
- reset=0 then 1, run=1, mem_ready=1, op_code=000000 -> states 0,1,2,7,8,1. instr_done pulses once; retired=1. EXEC has alu_op=10; ALU_WB has reg_write=1 and reg_dst=1.
- op_code=100010, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_req=1 and i_or_d=1. MEM_WB has mem_to_reg=1. Total 8 cycles; retired increments by 1.
- op_code=000100 -> DECODE shows alu_src_b=11. BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01. 3-cycle instruction.
- op_code=111111 at DECODE -> FAULT next cycle, fault=1, all strobes 0. State stays FAULT for 20 cycles until reset=0.
- MEM_TIMEOUT=15, mem_ready=0 in FETCH:
  - 15 not-ready cycles -> FAULT.
  - Repeat with mem_ready=1 in the 15th cycle -> DECODE, no fault.
- run dropped during LW MEM_RD -> LW completes, retired increments, state -> IDLE. Re-raising run -> FETCH next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and datapath-select encodings for the multicycle MIPS sequencer
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd10
  } state_e;
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts not-ready cycles of a memory wait; expired flags the last tolerated cycle
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  assign expired_o = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer stepping MIPS instructions through fetch/decode/execute/memory/writeback
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       op_code,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             fault,
  output logic [3:0]       state_dbg
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic wait_st, expired, unused_zero;
  assign unused_zero = zero_flag;
  assign wait_st = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // any state change restarts the watchdog, including MEM_WR straight back into FETCH
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!wait_st || state_d != state_q),
    .en_i      (!mem_ready),
    .expired_o (expired)
  );
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        state_d   = (op_code == OP_ADD || op_code == OP_SUB) ? S_EXEC :
                    (op_code == OP_LW || op_code == OP_SW)   ? S_MEM_ADDR :
                    (op_code == OP_BEQ)                      ? S_BRANCH : S_FAULT;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = op_code == OP_LW ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : expired ? S_FAULT : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = expired ? S_FAULT : S_MEM_WR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = op_code == OP_SUB ? ALU_SUB : ALU_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        instr_done    = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (instr_done) state_d = run ? S_FETCH : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= instr_done ? retired_q + CNT_W'(1) : retired_q;
    end
  assign retired   = retired_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenario tests for the multicycle sequencer
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
  logic [5:0] op_code = 6'b0;
  logic mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done, fault;
  logic [31:0] retired;
  logic [3:0] state_dbg;
  int checks = 0, failures = 0;
  wire [7:0] strobes = {mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, instr_done};
  wire [9:0] selects = {i_or_d, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .op_code(op_code), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .retired(retired), .fault(fault), .state_dbg(state_dbg)
  );

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    tick();
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if (strobes !== 8'h00) begin failures++; $display("FAIL reset_strobes got=%h exp=00", strobes); end
    checks++; if (selects !== 10'h000) begin failures++; $display("FAIL reset_selects got=%h exp=000", selects); end
    checks++; if (retired !== 32'd0 || fault !== 1'b0) begin failures++; $display("FAIL reset_cnt_fault got=%0d/%b exp=0/0", retired, fault); end
  endtask

  task automatic test_rtype;
    int unsigned seq[5] = '{1, 2, 7, 8, 1};
    int pulses = 0;
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; op_code = 6'b000000;
    #1;
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL rtype_idle got=%0d exp=0", state_dbg); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_done === 1'b1) pulses++;
      checks++; if (state_dbg !== seq[i][3:0]) begin failures++; $display("FAIL rtype_seq%0d got=%0d exp=%0d", i, state_dbg, seq[i]); end
      if (i == 0) begin
        checks++; if ({ir_write, pc_write, alu_src_b} !== 4'b1101) begin failures++; $display("FAIL fetch_ctl got=%b exp=1101", {ir_write, pc_write, alu_src_b}); end
      end
      if (i == 2) begin
        checks++; if (alu_op !== 2'b10 || alu_src_a !== 1'b1) begin failures++; $display("FAIL exec_aluop got=%b/%b exp=10/1", alu_op, alu_src_a); end
      end
      if (i == 3) begin
        checks++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin failures++; $display("FAIL aluwb_ctl got=%b exp=110", {reg_write, reg_dst, mem_to_reg}); end
      end
    end
    checks++; if (pulses != 1 || retired !== 32'd1) begin failures++; $display("FAIL rtype_retire got=%0d/%0d exp=1/1", pulses, retired); end
  endtask

  task automatic test_lw_stall;
    int cyc = 1;
    op_code = 6'b100010;
    tick(); cyc++;
    tick(); cyc++;
    checks++; if (state_dbg !== 4'd3 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin failures++; $display("FAIL memaddr got=%0d/%b/%b exp=3/10/1", state_dbg, alu_src_b, alu_src_a); end
    tick(); cyc++;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++; if (state_dbg !== 4'd4 || mem_req !== 1'b1 || i_or_d !== 1'b1) begin failures++; $display("FAIL memrd_hold%0d got=%0d/%b/%b exp=4/1/1", i, state_dbg, mem_req, i_or_d); end
      tick(); if (i < 3) cyc++;
    end
    cyc++;
    checks++; if (state_dbg !== 4'd5 || {reg_write, mem_to_reg, reg_dst, instr_done} !== 4'b1101) begin failures++; $display("FAIL memwb got=%0d/%b exp=5/1101", state_dbg, {reg_write, mem_to_reg, reg_dst, instr_done}); end
    checks++; if (cyc != 8) begin failures++; $display("FAIL lw_latency got=%0d exp=8", cyc); end
    tick();
    checks++; if (state_dbg !== 4'd1 || retired !== 32'd2) begin failures++; $display("FAIL lw_retire got=%0d/%0d exp=1/2", state_dbg, retired); end
  endtask

  task automatic test_beq;
    op_code = 6'b000100;
    tick();
    checks++; if (state_dbg !== 4'd2 || alu_src_b !== 2'b11) begin failures++; $display("FAIL decode_srcb got=%0d/%b exp=2/11", state_dbg, alu_src_b); end
    tick();
    checks++; if (state_dbg !== 4'd9 || {pc_write_cond, pc_source, alu_op, pc_write, instr_done} !== 7'b1010101) begin failures++; $display("FAIL branch_ctl got=%0d/%b exp=9/1010101", state_dbg, {pc_write_cond, pc_source, alu_op, pc_write, instr_done}); end
    tick();
    checks++; if (state_dbg !== 4'd1 || retired !== 32'd3) begin failures++; $display("FAIL beq_retire got=%0d/%0d exp=1/3", state_dbg, retired); end
  endtask

  task automatic test_sw;
    op_code = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    checks++; if (state_dbg !== 4'd6 || mem_write !== 1'b1 || mem_read !== 1'b0 || instr_done !== 1'b0) begin failures++; $display("FAIL memwr_wait got=%0d/%b/%b/%b exp=6/1/0/0", state_dbg, mem_write, mem_read, instr_done); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (instr_done !== 1'b1) begin failures++; $display("FAIL memwr_done got=%b exp=1", instr_done); end
    tick();
    checks++; if (state_dbg !== 4'd1 || retired !== 32'd4) begin failures++; $display("FAIL sw_retire got=%0d/%0d exp=1/4", state_dbg, retired); end
  endtask

  task automatic test_run_drop;
    op_code = 6'b100010;
    tick(); tick(); tick();
    run = 1'b0; mem_ready = 1'b0;
    tick();
    checks++; if (state_dbg !== 4'd4) begin failures++; $display("FAIL rundrop_hold got=%0d exp=4", state_dbg); end
    mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_dbg !== 4'd0 || retired !== 32'd5) begin failures++; $display("FAIL rundrop_idle got=%0d/%0d exp=0/5", state_dbg, retired); end
    tick();
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL rundrop_stay got=%0d exp=0", state_dbg); end
    run = 1'b1;
    tick();
    checks++; if (state_dbg !== 4'd1) begin failures++; $display("FAIL rerun_fetch got=%0d exp=1", state_dbg); end
  endtask

  task automatic test_fetch_timeout;
    int stuck = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (state_dbg !== 4'd1 || fault !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0d/%b exp=1/0", state_dbg, fault); end
    tick();
    checks++; if (state_dbg !== 4'd10 || fault !== 1'b1 || strobes !== 8'h00) begin failures++; $display("FAIL timeout_fault got=%0d/%b/%h exp=10/1/00", state_dbg, fault, strobes); end
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (state_dbg !== 4'd10) stuck++; end
    checks++; if (stuck != 0 || retired !== 32'd5) begin failures++; $display("FAIL fault_sticky got=%0d/%0d exp=0/5", stuck, retired); end
    reset = 1'b0;
    #1;
    checks++; if (state_dbg !== 4'd0 || fault !== 1'b0 || retired !== 32'd0) begin failures++; $display("FAIL fault_reset got=%0d/%b/%0d exp=0/0/0", state_dbg, fault, retired); end
  endtask

  task automatic test_timeout_edge;
    tick();
    reset = 1'b1; run = 1'b1; op_code = 6'b000000; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (state_dbg !== 4'd1 || fault !== 1'b0) begin failures++; $display("FAIL edge_wait got=%0d/%b exp=1/0", state_dbg, fault); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ir_write !== 1'b1) begin failures++; $display("FAIL edge_irwrite got=%b exp=1", ir_write); end
    tick();
    checks++; if (state_dbg !== 4'd2 || fault !== 1'b0) begin failures++; $display("FAIL edge_decode got=%0d/%b exp=2/0", state_dbg, fault); end
  endtask

  task automatic test_illegal;
    int stuck = 0;
    tick(); tick(); tick();
    op_code = 6'b111111;
    tick();
    checks++; if (state_dbg !== 4'd2) begin failures++; $display("FAIL illegal_decode got=%0d exp=2", state_dbg); end
    tick();
    checks++; if (state_dbg !== 4'd10 || fault !== 1'b1 || strobes !== 8'h00) begin failures++; $display("FAIL illegal_fault got=%0d/%b/%h exp=10/1/00", state_dbg, fault, strobes); end
    for (int i = 0; i < 20; i++) begin tick(); if (state_dbg !== 4'd10) stuck++; end
    checks++; if (stuck != 0) begin failures++; $display("FAIL illegal_sticky got=%0d exp=0", stuck); end
  endtask

  task automatic test_mid_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; op_code = 6'b000000;
    tick();
    checks++; if (state_dbg !== 4'd1 || ir_write !== 1'b1) begin failures++; $display("FAIL midreset_fetch got=%0d/%b exp=1/1", state_dbg, ir_write); end
    reset = 1'b0;
    #1;
    checks++; if (state_dbg !== 4'd0 || strobes !== 8'h00) begin failures++; $display("FAIL midreset_async got=%0d/%h exp=0/00", state_dbg, strobes); end
    tick();
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL midreset_hold got=%0d exp=0", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_sw();
    test_run_drop();
    test_fetch_timeout();
    test_timeout_edge();
    test_illegal();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
